// File: rtl/chain_config_engine.sv
// Serial configuration engine for the TDC and ASD scan chains.
// Each chain is shifted twice with identical data. The second pass returns the
// first pass's contents on tdo, and the engine compares that readback against
// data_bit to set the chain's success flag.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | waiting for a start edge or a pending ASD run
// LOAD      | one cycle: clear bit/pass/mismatch, raise chain_en
// SHIFT_LO  | tck low for TCK_HALF cycles, tdi launched on first cycle
// SHIFT_HI  | tck high for TCK_HALF cycles, tdo checked on first cycle
// DONE      | one cycle: completion pulse for the run, busy still high
module chain_config_engine #(
    parameter int unsigned TCK_HALF     = 4,
    parameter int unsigned LEN_SETUP0   = 115,
    parameter int unsigned LEN_SETUP1   = 19,
    parameter int unsigned LEN_SETUP2   = 145,
    parameter int unsigned LEN_CONTROL0 = 8,
    parameter int unsigned LEN_CONTROL1 = 47,
    parameter int unsigned LEN_ASD      = 53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TDC_loop_start,
    input  logic       ASD_loop_start,
    input  logic       loop_TRST,
    input  logic       data_bit,
    input  logic       tdo,
    output logic [2:0] chain_idx,
    output logic [7:0] bit_idx,
    output logic [5:0] chain_en,
    output logic       tck,
    output logic       tdi,
    output logic       tdc_config_done,
    output logic       asd_config_done,
    output logic [5:0] chain_success,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(TCK_HALF - 1);

    state_t     state;
    logic [7:0] half_cnt;
    logic       pass_q;
    logic       mismatch;
    logic       run_asd;
    logic       asd_pending;
    logic       tdc_start_q;
    logic       asd_start_q;

    logic       tdc_edge;
    logic       asd_edge;
    logic       first_cyc;
    logic       mismatch_now;
    logic [7:0] len_m1;

    assign tdc_edge     = TDC_loop_start & ~tdc_start_q;
    assign asd_edge     = ASD_loop_start & ~asd_start_q;
    assign first_cyc    = (half_cnt == HALF_LAST);
    // With TCK_HALF=1 the readback check and the chain completion share a cycle.
    assign mismatch_now = pass_q & first_cyc & (tdo != data_bit);

    // Last bit index of the chain currently selected.
    always_comb begin
        len_m1 = 8'(LEN_ASD - 1);
        case (chain_idx)
            3'd0:    len_m1 = 8'(LEN_SETUP0 - 1);
            3'd1:    len_m1 = 8'(LEN_SETUP1 - 1);
            3'd2:    len_m1 = 8'(LEN_SETUP2 - 1);
            3'd3:    len_m1 = 8'(LEN_CONTROL0 - 1);
            3'd4:    len_m1 = 8'(LEN_CONTROL1 - 1);
            default: len_m1 = 8'(LEN_ASD - 1);
        endcase
    end

    // Run sequencing, tck/tdi generation and readback checking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            half_cnt        <= '0;
            pass_q          <= 1'b0;
            mismatch        <= 1'b0;
            run_asd         <= 1'b0;
            asd_pending     <= 1'b0;
            tdc_start_q     <= 1'b0;
            asd_start_q     <= 1'b0;
            chain_idx       <= '0;
            bit_idx         <= '0;
            chain_en        <= '0;
            tck             <= 1'b0;
            tdi             <= 1'b0;
            tdc_config_done <= 1'b0;
            asd_config_done <= 1'b0;
            chain_success   <= '0;
            busy            <= 1'b0;
        end else begin
            tdc_start_q     <= TDC_loop_start;
            asd_start_q     <= ASD_loop_start;
            tdc_config_done <= 1'b0;
            asd_config_done <= 1'b0;
            if (!loop_TRST) begin
                state       <= S_IDLE;
                tck         <= 1'b0;
                tdi         <= 1'b0;
                chain_en    <= '0;
                asd_pending <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (asd_pending) begin
                            asd_pending <= 1'b0;
                            run_asd     <= 1'b1;
                            chain_idx   <= 3'd5;
                            busy        <= 1'b1;
                            state       <= S_LOAD;
                        end else if (tdc_edge) begin
                            asd_pending <= asd_edge;
                            run_asd     <= 1'b0;
                            chain_idx   <= 3'd0;
                            busy        <= 1'b1;
                            state       <= S_LOAD;
                        end else if (asd_edge) begin
                            run_asd     <= 1'b1;
                            chain_idx   <= 3'd5;
                            busy        <= 1'b1;
                            state       <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        bit_idx  <= '0;
                        pass_q   <= 1'b0;
                        mismatch <= 1'b0;
                        chain_en <= 6'(6'b100000 >> chain_idx);
                        half_cnt <= HALF_LAST;
                        tck      <= 1'b0;
                        state    <= S_SHIFT_LO;
                    end
                    S_SHIFT_LO: begin
                        if (first_cyc) tdi <= data_bit;
                        if (half_cnt == 8'd0) begin
                            half_cnt <= HALF_LAST;
                            tck      <= 1'b1;
                            state    <= S_SHIFT_HI;
                        end else begin
                            half_cnt <= half_cnt - 8'd1;
                        end
                    end
                    S_SHIFT_HI: begin
                        if (mismatch_now) mismatch <= 1'b1;
                        if (half_cnt == 8'd0) begin
                            half_cnt <= HALF_LAST;
                            tck      <= 1'b0;
                            if (bit_idx != len_m1) begin
                                bit_idx <= bit_idx + 8'd1;
                                state   <= S_SHIFT_LO;
                            end else if (!pass_q) begin
                                pass_q  <= 1'b1;
                                bit_idx <= '0;
                                state   <= S_SHIFT_LO;
                            end else begin
                                chain_en <= '0;
                                if (mismatch | mismatch_now)
                                    chain_success <= chain_success & ~chain_en;
                                else
                                    chain_success <= chain_success | chain_en;
                                if (!run_asd && chain_idx < 3'd4) begin
                                    chain_idx <= chain_idx + 3'd1;
                                    state     <= S_LOAD;
                                end else begin
                                    tdc_config_done <= ~run_asd;
                                    asd_config_done <= run_asd;
                                    state           <= S_DONE;
                                end
                            end
                        end else begin
                            half_cnt <= half_cnt - 8'd1;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
